mac_vec_pipe: RTL and testbench
===============================

MAC_VEC_PIPE -- requirements
Module: mac_vec_pipe

Interface
REQ-001 Parameter IN_W, default 8: width of signed operands a, b.
REQ-002 Parameter ACC_W, default 16: width of signed accumulator; SHALL be >= 2*IN_W.
REQ-003 Parameter VEC_LEN, default 4: products accumulated per result; SHALL be >= 1.
REQ-004 Parameter SAT, default 1: 1 = saturate at ACC_W limits, 0 = two's-complement wrap.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clr_n  input  1  synchronous clear, active-low.
REQ-008 in_vld  input  1  a/b valid.
REQ-009 in_rdy  output  1  block accepts a/b this cycle.
REQ-010 a  input  IN_W  signed operand.
REQ-011 b  input  IN_W  signed operand.
REQ-012 out_vld  output  1  acc/of/uf hold a completed result.
REQ-013 out_rdy  input  1  consumer accepts result.
REQ-014 acc  output  ACC_W  signed accumulated result.
REQ-015 of  output  1  sticky overflow for current vector.
REQ-016 uf  output  1  sticky underflow for current vector.

Function
REQ-017 Element accepted on a rising edge where in_vld && in_rdy && clr_n.
REQ-018 in_rdy SHALL depend only on registered state: high iff state ACCUM and issued-element count < VEC_LEN.
REQ-019 Stage 1: full 2*IN_W signed product a*b registered with a valid bit on the accepting edge.
REQ-020 Stage 2: on the edge after stage 1 holds a valid product, sign-extended product added to internal accumulator at ACC_W+1 bits.
REQ-021 Sum > 2^(ACC_W-1)-1: of set; result = max if SAT=1, low ACC_W bits if SAT=0.
REQ-022 Sum < -2^(ACC_W-1): uf set; result = min if SAT=1, low ACC_W bits if SAT=0.
REQ-023 of and uf sticky within a vector; both may be set in one vector when SAT=0; with SAT=1, saturated value continues as accumulator base.
REQ-024 States: ACCUM, DONE. ACCUM -> DONE on the edge accumulating element VEC_LEN; out_vld = 1 in DONE only.
REQ-025 Latency: last element accepted at edge E -> out_vld high after edge E+1 (2 cycles).
REQ-026 In DONE, acc/of/uf stable and in_rdy = 0 until out_rdy sampled high.
REQ-027 DONE with out_rdy = 1 -> ACCUM: counters, internal accumulator, of, uf zeroed; in_rdy high the next cycle; acc holds last result until the next accumulation.
REQ-028 in_vld low mid-vector: pipeline bubbles; no state change except draining stage 1.
REQ-029 acc output SHALL show internal accumulator continuously in ACCUM (running sum); only values with out_vld = 1 are results.
REQ-030 clr_n low at an edge (highest priority after rst_n): accumulator, acc, counters, stage-1 valid, of, uf, out_vld zeroed; state ACCUM; a/b presented that cycle discarded; pending result dropped.

Reset
REQ-031 rst_n low asynchronously forces: acc = 0, of = 0, uf = 0, out_vld = 0, stage-1 valid = 0, counters = 0, state ACCUM; in_rdy = 1 once rst_n deasserted.
REQ-032 rst_n asserted mid-vector or in DONE discards all in-flight data; no output retained.

Verification (defaults, VEC_LEN = 4)
REQ-033 Basic: a = 1,2,3,4, b = 2, in_vld continuous, out_rdy = 1 -> out_vld one cycle, acc = 20, of = uf = 0, 2 cycles after last accept.
REQ-034 Saturation, SAT = 1: four of a = 127, b = 127 -> acc = 32767, of = 1, uf = 0; four of a = -128, b = 127 -> acc = -32768, uf = 1.
REQ-035 Wrap, SAT = 0: four of a = 127, b = 127 -> acc = -1020, of = 1.
REQ-036 Backpressure: out_rdy = 0 for 5 cycles after out_vld -> out_vld, acc, of, uf stable; in_rdy = 0; next vector accumulates from 0 with flags cleared after out_rdy = 1.
REQ-037 Bubbles and clear: in_vld toggled 1,0,1,0... -> same result as REQ-033; clr_n pulsed low after 2 accepts -> out_vld 0, acc 0, next 4 accepts give fresh result.
REQ-038 Async reset: rst_n low mid-vector between clock edges -> all outputs 0 immediately, in_rdy = 1 after release.

Source files
------------

// File: rtl/mac_vec_pipe.sv
// Pipelined signed vector multiply-accumulate: multiply stage, accumulate stage,
// and a result held in DONE until the consumer takes it.
module mac_vec_pipe #(
   parameter int IN_W    = 8,
   parameter int ACC_W   = 16,
   parameter int VEC_LEN = 4,
   parameter int SAT     = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [IN_W-1:0]  a,
   input  logic [IN_W-1:0]  b,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [ACC_W-1:0] acc,
   output logic             of,
   output logic             uf,
   output logic             dbg_state
);

   localparam int CNT_W = $clog2(VEC_LEN + 1);
   localparam int P_W   = 2 * IN_W;

   typedef enum logic {ST_ACCUM = 1'b0, ST_DONE = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   iss_q, iss_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               p_vld_q, p_vld_d;
   logic [P_W-1:0]     prod_q, prod_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   res_q, res_d;
   logic               of_q, of_d;
   logic               uf_q, uf_d;

   logic signed [P_W-1:0] a_x, b_x;
   logic [ACC_W:0]        sum;
   logic                  of_hit, uf_hit;
   logic [ACC_W-1:0]      sat_res;
   logic                  accept;

   // Ready comes from registered state only, never from in_vld or out_rdy.
   assign in_rdy    = (state_q == ST_ACCUM) && (iss_q < CNT_W'(VEC_LEN));
   assign out_vld   = (state_q == ST_DONE);
   assign acc       = res_q;
   assign of        = of_q;
   assign uf        = uf_q;
   assign dbg_state = state_q;

   assign accept = in_vld && in_rdy;
   assign a_x    = $signed({{IN_W{a[IN_W-1]}}, a});
   assign b_x    = $signed({{IN_W{b[IN_W-1]}}, b});

   // One guard bit: top two sum bits disagreeing means the ACC_W range was left.
   assign sum    = {{(ACC_W + 1 - P_W){prod_q[P_W-1]}}, prod_q} + {acc_q[ACC_W-1], acc_q};
   assign of_hit = ~sum[ACC_W] & sum[ACC_W-1];
   assign uf_hit = sum[ACC_W] & ~sum[ACC_W-1];

   always_comb begin
      sat_res = sum[ACC_W-1:0];
      if (SAT != 0 && of_hit) sat_res = {1'b0, {(ACC_W-1){1'b1}}};
      if (SAT != 0 && uf_hit) sat_res = {1'b1, {(ACC_W-1){1'b0}}};
   end

   always_comb begin
      state_d = state_q;
      iss_d   = iss_q;
      cnt_d   = cnt_q;
      p_vld_d = accept;
      prod_d  = prod_q;
      acc_d   = acc_q;
      res_d   = res_q;
      of_d    = of_q;
      uf_d    = uf_q;

      if (accept) begin
         prod_d = P_W'(a_x * b_x);
         iss_d  = iss_q + CNT_W'(1);
      end

      if (p_vld_q) begin
         acc_d = sat_res;
         res_d = sat_res;
         of_d  = of_q | of_hit;
         uf_d  = uf_q | uf_hit;
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(VEC_LEN - 1)) state_d = ST_DONE;
      end

      // Leaving DONE restarts the vector but keeps the last result on acc.
      if (state_q == ST_DONE && out_rdy) begin
         state_d = ST_ACCUM;
         iss_d   = '0;
         cnt_d   = '0;
         acc_d   = '0;
         of_d    = 1'b0;
         uf_d    = 1'b0;
      end

      if (!clr_n) begin
         state_d = ST_ACCUM;
         iss_d   = '0;
         cnt_d   = '0;
         p_vld_d = 1'b0;
         acc_d   = '0;
         res_d   = '0;
         of_d    = 1'b0;
         uf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACCUM;
         iss_q   <= '0;
         cnt_q   <= '0;
         p_vld_q <= 1'b0;
         prod_q  <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         of_q    <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         iss_q   <= iss_d;
         cnt_q   <= cnt_d;
         p_vld_q <= p_vld_d;
         prod_q  <= prod_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         of_q    <= of_d;
         uf_q    <= uf_d;
      end
   end

endmodule

// File: tb/tb_mac_vec_pipe.sv
// Directed bench for mac_vec_pipe: a saturating and a wrapping instance share
// one stimulus stream; expected values are hand-computed constants.
module tb_mac_vec_pipe;

   logic        clk;
   logic        rst_n;
   logic        clr_n;
   logic        in_vld;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_rdy;

   logic        in_rdy_s, out_vld_s, of_s, uf_s, st_s;
   logic [15:0] acc_s;
   logic        in_rdy_w, out_vld_w, of_w, uf_w, st_w;
   logic [15:0] acc_w;

   int n_checks = 0;
   int n_fail   = 0;

   mac_vec_pipe #(.IN_W(8), .ACC_W(16), .VEC_LEN(4), .SAT(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .in_rdy(in_rdy_s),
      .a(a), .b(b), .out_vld(out_vld_s), .out_rdy(out_rdy), .acc(acc_s),
      .of(of_s), .uf(uf_s), .dbg_state(st_s)
   );

   mac_vec_pipe #(.IN_W(8), .ACC_W(16), .VEC_LEN(4), .SAT(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .in_vld(in_vld), .in_rdy(in_rdy_w),
      .a(a), .b(b), .out_vld(out_vld_w), .out_rdy(out_rdy), .acc(acc_w),
      .of(of_w), .uf(uf_w), .dbg_state(st_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one element and returns 1 time unit after the accepting edge.
   task automatic send(input int av, input int bv);
      int n;
      n = 0;
      in_vld = 1'b1;
      a = 8'(av);
      b = 8'(bv);
      while (!(in_rdy_s && in_rdy_w) && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) check("send_timeout", 32'(n), 0);
      step();
      in_vld = 1'b0;
   endtask

   // Called right after the last accept; result is due after one more edge.
   task automatic wait_out(input string tag);
      int n;
      n = 0;
      check({tag, "_vld_early"}, out_vld_s, 0);
      while (!out_vld_s && n < 8) begin
         step();
         n++;
      end
      check({tag, "_latency"}, 32'(n), 1);
   endtask

   initial begin
      rst_n   = 1'b0;
      clr_n   = 1'b1;
      in_vld  = 1'b0;
      a       = '0;
      b       = '0;
      out_rdy = 1'b1;
      #1;
      check("rst_acc", $signed(acc_s), 0);
      check("rst_vld", out_vld_s, 0);
      check("rst_of", of_s, 0);
      check("rst_uf", uf_s, 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check("rst_rdy", in_rdy_s, 1);

      // basic dot product, continuous input
      send(1, 2);
      check("basic_run0", $signed(acc_s), 0);
      send(2, 2);
      check("basic_run1", $signed(acc_s), 2);
      send(3, 2);
      send(4, 2);
      wait_out("basic");
      check("basic_acc", $signed(acc_s), 20);
      check("basic_acc_w", $signed(acc_w), 20);
      check("basic_of", of_s, 0);
      check("basic_uf", uf_s, 0);
      step();
      check("basic_vld_1cyc", out_vld_s, 0);
      check("basic_rdy_after", in_rdy_s, 1);
      check("basic_acc_hold", $signed(acc_s), 20);

      // positive saturation / wrap
      repeat (4) send(127, 127);
      wait_out("satp");
      check("satp_acc", $signed(acc_s), 32767);
      check("satp_of", of_s, 1);
      check("satp_uf", uf_s, 0);
      check("wrapp_acc", $signed(acc_w), -1020);
      check("wrapp_of", of_w, 1);
      check("wrapp_uf", uf_w, 0);
      step();

      // negative saturation / wrap
      repeat (4) send(-128, 127);
      wait_out("satn");
      check("satn_acc", $signed(acc_s), -32768);
      check("satn_uf", uf_s, 1);
      check("satn_of", of_s, 0);
      check("wrapn_acc", $signed(acc_w), 512);
      check("wrapn_uf", uf_w, 1);
      check("wrapn_of", of_w, 0);
      step();

      // backpressure: result held, input refused
      out_rdy = 1'b0;
      send(5, 3);
      send(-3, 3);
      send(7, 3);
      send(2, 3);
      wait_out("bp");
      in_vld = 1'b1;
      a = 8'd100;
      b = 8'd100;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_vld", out_vld_s, 1);
         check("bp_acc", $signed(acc_s), 33);
         check("bp_rdy", in_rdy_s, 0);
         check("bp_of", of_s, 0);
         check("bp_uf", uf_s, 0);
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      step();
      check("bp_exit_vld", out_vld_s, 0);
      check("bp_exit_rdy", in_rdy_s, 1);
      check("bp_exit_acc", $signed(acc_s), 33);
      repeat (4) send(1, 1);
      wait_out("bp_next");
      check("bp_next_acc", $signed(acc_s), 4);
      step();

      // bubbles between elements
      for (int i = 1; i <= 4; i++) begin
         send(i, 2);
         if (i < 4) begin
            step();
            check("bub_rdy", in_rdy_s, 1);
         end
      end
      wait_out("bub");
      check("bub_acc", $signed(acc_s), 20);
      step();

      // synchronous clear mid-vector, with a product in flight
      send(10, 10);
      send(10, 10);
      check("clr_pre", $signed(acc_s), 100);
      clr_n  = 1'b0;
      in_vld = 1'b1;
      a = 8'd50;
      b = 8'd50;
      step();
      clr_n  = 1'b1;
      in_vld = 1'b0;
      check("clr_acc", $signed(acc_s), 0);
      check("clr_vld", out_vld_s, 0);
      check("clr_rdy", in_rdy_s, 1);
      step();
      check("clr_acc_drain", $signed(acc_s), 0);
      send(1, 1);
      send(2, 2);
      send(3, 3);
      send(4, 4);
      wait_out("clr_next");
      check("clr_next_acc", $signed(acc_s), 30);
      step();

      // clear drops a pending result
      out_rdy = 1'b0;
      repeat (4) send(2, 2);
      wait_out("clrd");
      check("clrd_acc", $signed(acc_s), 16);
      clr_n = 1'b0;
      step();
      clr_n   = 1'b1;
      out_rdy = 1'b1;
      check("clrd_vld", out_vld_s, 0);
      check("clrd_acc0", $signed(acc_s), 0);
      check("clrd_rdy", in_rdy_s, 1);

      // asynchronous reset between edges
      send(3, 3);
      send(3, 3);
      check("arst_pre", $signed(acc_s), 9);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_acc", $signed(acc_s), 0);
      check("arst_vld", out_vld_s, 0);
      check("arst_of", of_s, 0);
      step();
      rst_n = 1'b1;
      step();
      check("arst_rdy", in_rdy_s, 1);
      check("arst_acc_rel", $signed(acc_s), 0);
      repeat (4) send(2, 3);
      wait_out("arst_next");
      check("arst_next_acc", $signed(acc_s), 24);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
